// File: rtl/wb_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module   : wb_bus_monitor
// Brief    : Passive Wishbone (classic / B4 pipelined) handshake checker with
//            sticky flags, first-violation capture and saturating statistics.
// Revision : 1.0 - initial release
// ============================================================================
module wb_bus_monitor #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int GRANULE         = 8,
    parameter int PIPELINED       = 1,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int CNT_WIDTH       = 16,
    localparam int SEL_WIDTH      = DATA_WIDTH / GRANULE,
    localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    input  logic                  ack_o,
    input  logic                  err_o,
    input  logic                  stall_o,
    input  logic [6:0]            en_mask_i,
    input  logic                  clr_i,
    output logic [6:0]            viol_o,
    output logic [6:0]            sticky_o,
    output logic                  first_vld_o,
    output logic [2:0]            first_idx_o,
    output logic                  irq_o,
    output logic [OUT_W-1:0]      outstanding_o,
    output logic [CNT_WIDTH-1:0]  txn_cnt_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic [CNT_WIDTH-1:0]  viol_cnt_o
);

    localparam int               C_MAX_EFF = (PIPELINED != 0) ? MAX_OUTSTANDING : 1;
    localparam int               C_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [OUT_W-1:0]  C_MAX     = OUT_W'(C_MAX_EFF);
    localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [C_TO_W-1:0] C_TO_FULL = C_TO_W'(TIMEOUT_CYCLES);

    logic [OUT_W-1:0]      r_outs;
    logic [C_TO_W-1:0]     r_to_cnt;
    logic                  r_to_fired;
    logic                  r_cyc_d;
    logic                  r_hold_pend;
    logic [ADDR_WIDTH-1:0] r_snap_adr;
    logic                  r_snap_we;
    logic [DATA_WIDTH-1:0] r_snap_dat;
    logic [SEL_WIDTH-1:0]  r_snap_sel;
    logic [6:0]            r_viol;
    logic [6:0]            r_sticky;
    logic                  r_first_vld;
    logic [2:0]            r_first_idx;
    logic                  r_irq;
    logic [CNT_WIDTH-1:0]  r_txn;
    logic [CNT_WIDTH-1:0]  r_err;
    logic [CNT_WIDTH-1:0]  r_vcnt;

    logic                  w_resp;
    logic                  w_accept;
    logic [OUT_W:0]        w_sum;
    logic [OUT_W:0]        w_diff;
    logic [OUT_W-1:0]      w_outs_next;
    logic                  w_hold_arm;
    logic                  w_hold_bad;
    logic [6:0]            w_viol;
    logic [2:0]            w_first;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] base,
                                                     input logic                 inc);
        if (inc && (base != {CNT_WIDTH{1'b1}}))
            return base + CNT_WIDTH'(1);
        return base;
    endfunction

    always_comb begin
        w_resp = ack_o | err_o;
        if (PIPELINED != 0)
            w_accept = cyc_i & stb_i & ~stall_o;
        else
            w_accept = cyc_i & stb_i & (r_outs == '0);

        w_sum  = {1'b0, r_outs} + {{OUT_W{1'b0}}, w_accept};
        w_diff = w_sum - {{OUT_W{1'b0}}, w_resp};

        // Count never wraps: a response with nothing pending leaves it at 0.
        w_outs_next = r_outs;
        if (!cyc_i)
            w_outs_next = '0;
        else if (w_resp && (w_sum == '0))
            w_outs_next = '0;
        else if (w_diff > {1'b0, C_MAX})
            w_outs_next = C_MAX;
        else
            w_outs_next = w_diff[OUT_W-1:0];

        if (PIPELINED != 0)
            w_hold_arm = cyc_i & stb_i & stall_o;
        else
            w_hold_arm = cyc_i & stb_i & ~w_resp;

        w_hold_bad = r_hold_pend & (~stb_i | (adr_i != r_snap_adr) | (we_i != r_snap_we) |
                                    (dat_i != r_snap_dat) | (sel_i != r_snap_sel));

        w_viol    = '0;
        w_viol[0] = ack_o & err_o;
        w_viol[1] = w_resp & ~cyc_i;
        w_viol[2] = w_resp & cyc_i & (w_sum == '0);
        w_viol[3] = (r_outs != '0) & ~w_resp & (r_to_cnt == C_TO_LAST) & ~r_to_fired;
        w_viol[4] = w_hold_bad;
        w_viol[5] = w_accept & (r_outs == C_MAX);
        w_viol[6] = r_cyc_d & ~cyc_i & (r_outs != '0) & ~w_resp;

        w_first = '0;
        for (int i = 6; i >= 0; i--) begin
            if (w_viol[i])
                w_first = 3'(i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outs      <= '0;
            r_to_cnt    <= '0;
            r_to_fired  <= 1'b0;
            r_cyc_d     <= 1'b0;
            r_hold_pend <= 1'b0;
            r_snap_adr  <= '0;
            r_snap_we   <= 1'b0;
            r_snap_dat  <= '0;
            r_snap_sel  <= '0;
            r_viol      <= '0;
            r_sticky    <= '0;
            r_first_vld <= 1'b0;
            r_first_idx <= '0;
            r_irq       <= 1'b0;
            r_txn       <= '0;
            r_err       <= '0;
            r_vcnt      <= '0;
        end else begin
            r_outs      <= w_outs_next;
            r_cyc_d     <= cyc_i;
            r_hold_pend <= w_hold_arm;
            r_snap_adr  <= adr_i;
            r_snap_we   <= we_i;
            r_snap_dat  <= dat_i;
            r_snap_sel  <= sel_i;

            if ((r_outs == '0) || w_resp)
                r_to_cnt <= '0;
            else if (r_to_cnt != C_TO_FULL)
                r_to_cnt <= r_to_cnt + C_TO_W'(1);
            // A clear re-arms the timeout, but a timeout in the same cycle still latches.
            r_to_fired <= (r_to_fired & ~clr_i) | w_viol[3];

            r_viol   <= w_viol;
            r_sticky <= (clr_i ? 7'd0 : r_sticky) | w_viol;
            r_irq    <= |(r_sticky & en_mask_i);

            if ((|w_viol) && (clr_i || !r_first_vld)) begin
                r_first_vld <= 1'b1;
                r_first_idx <= w_first;
            end else if (clr_i) begin
                r_first_vld <= 1'b0;
                r_first_idx <= '0;
            end

            r_txn  <= sat_inc(clr_i ? '0 : r_txn, ack_o & cyc_i);
            r_err  <= sat_inc(clr_i ? '0 : r_err, err_o & cyc_i);
            r_vcnt <= sat_inc(clr_i ? '0 : r_vcnt, |w_viol);
        end
    end

    assign viol_o        = r_viol;
    assign sticky_o      = r_sticky;
    assign first_vld_o   = r_first_vld;
    assign first_idx_o   = r_first_idx;
    assign irq_o         = r_irq;
    assign outstanding_o = r_outs;
    assign txn_cnt_o     = r_txn;
    assign err_cnt_o     = r_err;
    assign viol_cnt_o    = r_vcnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_bus_monitor
// Brief    : Directed vector bench for wb_bus_monitor (pipelined, 8-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_bus_monitor;

    localparam int C_CNT_W = 8;

    typedef struct packed {
        logic [6:0] viol;
        logic [2:0] outs;
        logic [6:0] sticky;
        logic [7:0] txn;
        logic [7:0] errc;
        logic [7:0] vcnt;
        logic       irq;
        logic       fvld;
        logic [2:0] fidx;
    } st_t;

    typedef struct {
        logic        cyc;
        logic        stb;
        logic [15:0] adr;
        logic        ack;
        logic        err;
        logic        stall;
        st_t         exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i = 1'b0;
    logic [15:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [3:0]  sel_i = 4'hf;
    logic        ack_o = 1'b0;
    logic        err_o = 1'b0;
    logic        stall_o = 1'b0;
    logic [6:0]  en_mask_i = 7'h01;
    logic        clr_i = 1'b0;
    logic [6:0]  viol_o;
    logic [6:0]  sticky_o;
    logic        first_vld_o;
    logic [2:0]  first_idx_o;
    logic        irq_o;
    logic [2:0]  outstanding_o;
    logic [C_CNT_W-1:0] txn_cnt_o;
    logic [C_CNT_W-1:0] err_cnt_o;
    logic [C_CNT_W-1:0] viol_cnt_o;

    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vecs[$];

    wb_bus_monitor #(
        .ADDR_WIDTH     (16),
        .DATA_WIDTH     (32),
        .GRANULE        (8),
        .PIPELINED      (1),
        .MAX_OUTSTANDING(4),
        .TIMEOUT_CYCLES (16),
        .CNT_WIDTH      (C_CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cyc_i        (cyc_i),
        .stb_i        (stb_i),
        .we_i         (we_i),
        .adr_i        (adr_i),
        .dat_i        (dat_i),
        .sel_i        (sel_i),
        .ack_o        (ack_o),
        .err_o        (err_o),
        .stall_o      (stall_o),
        .en_mask_i    (en_mask_i),
        .clr_i        (clr_i),
        .viol_o       (viol_o),
        .sticky_o     (sticky_o),
        .first_vld_o  (first_vld_o),
        .first_idx_o  (first_idx_o),
        .irq_o        (irq_o),
        .outstanding_o(outstanding_o),
        .txn_cnt_o    (txn_cnt_o),
        .err_cnt_o    (err_cnt_o),
        .viol_cnt_o   (viol_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic st_t cur();
        return '{viol_o, outstanding_o, sticky_o, txn_cnt_o, err_cnt_o, viol_cnt_o,
                 irq_o, first_vld_o, first_idx_o};
    endfunction

    function automatic string fmt(input st_t s);
        return $sformatf("viol=%b outs=%0d sticky=%b txn=%0d err=%0d vcnt=%0d irq=%b fvld=%b fidx=%0d",
                         s.viol, s.outs, s.sticky, s.txn, s.errc, s.vcnt, s.irq, s.fvld, s.fidx);
    endfunction

    task automatic check_st(input string name, input st_t exp);
        st_t got;
        got = cur();
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic cyc, input logic stb, input logic [15:0] adr,
                         input logic ack, input logic err, input logic stall);
        cyc_i   = cyc;
        stb_i   = stb;
        adr_i   = adr;
        ack_o   = ack;
        err_o   = err;
        stall_o = stall;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic cyc, input logic stb, input logic [15:0] adr,
                       input logic ack, input logic err, input logic stall,
                       input logic [6:0] viol, input logic [2:0] outs, input logic [6:0] sticky,
                       input logic [7:0] txn, input logic [7:0] errc, input logic [7:0] vcnt,
                       input logic irq, input logic fvld, input logic [2:0] fidx);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.adr = adr; v.ack = ack; v.err = err; v.stall = stall;
        v.exp = '{viol, outs, sticky, txn, errc, vcnt, irq, fvld, fidx};
        vecs.push_back(v);
    endtask

    initial begin
        int pulses;
        int at;

        // cyc stb adr ack err stall | viol outs sticky txn err vcnt irq fvld fidx
        add(1, 1, 16'h0000, 0, 0, 0, 7'h00, 1, 7'h00, 0, 0, 0, 0, 0, 0);
        add(1, 1, 16'h0004, 0, 0, 0, 7'h00, 2, 7'h00, 0, 0, 0, 0, 0, 0);
        add(1, 1, 16'h0008, 0, 0, 0, 7'h00, 3, 7'h00, 0, 0, 0, 0, 0, 0);
        add(1, 0, 16'h0008, 1, 0, 0, 7'h00, 2, 7'h00, 1, 0, 0, 0, 0, 0);
        add(1, 0, 16'h0008, 1, 0, 0, 7'h00, 1, 7'h00, 2, 0, 0, 0, 0, 0);
        add(1, 0, 16'h0008, 1, 0, 0, 7'h00, 0, 7'h00, 3, 0, 0, 0, 0, 0);
        add(0, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 7'h00, 3, 0, 0, 0, 0, 0);
        add(1, 1, 16'h0020, 0, 0, 0, 7'h00, 1, 7'h00, 3, 0, 0, 0, 0, 0);
        add(1, 0, 16'h0020, 1, 1, 0, 7'h01, 0, 7'h01, 4, 1, 1, 0, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 0, 7'h00, 0, 7'h01, 4, 1, 1, 1, 1, 0);
        add(1, 1, 16'h0010, 0, 0, 1, 7'h00, 0, 7'h01, 4, 1, 1, 1, 1, 0);
        add(1, 1, 16'h0014, 0, 0, 0, 7'h10, 1, 7'h11, 4, 1, 2, 1, 1, 0);
        add(1, 0, 16'h0014, 1, 0, 0, 7'h00, 0, 7'h11, 5, 1, 2, 1, 1, 0);
        add(1, 1, 16'h0030, 0, 0, 0, 7'h00, 1, 7'h11, 5, 1, 2, 1, 1, 0);
        add(1, 1, 16'h0034, 0, 0, 0, 7'h00, 2, 7'h11, 5, 1, 2, 1, 1, 0);
        add(1, 1, 16'h0038, 0, 0, 0, 7'h00, 3, 7'h11, 5, 1, 2, 1, 1, 0);
        add(1, 1, 16'h003c, 0, 0, 0, 7'h00, 4, 7'h11, 5, 1, 2, 1, 1, 0);
        add(1, 1, 16'h0040, 0, 0, 0, 7'h20, 4, 7'h31, 5, 1, 3, 1, 1, 0);
        add(0, 0, 16'h0000, 0, 0, 0, 7'h40, 0, 7'h71, 5, 1, 4, 1, 1, 0);
        add(1, 0, 16'h0000, 1, 0, 0, 7'h04, 0, 7'h75, 6, 1, 5, 1, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        check_st("reset", '0);
        rst_i = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].cyc, vecs[i].stb, vecs[i].adr, vecs[i].ack, vecs[i].err, vecs[i].stall);
            step();
            check_st($sformatf("vec%0d", i), vecs[i].exp);
        end

        // One accept, then silence: exactly one timeout pulse on the 16th stalled sample.
        drive(1, 1, 16'h0050, 0, 0, 0);
        step();
        drive(1, 0, 16'h0050, 0, 0, 0);
        pulses = 0;
        at     = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (viol_o[3]) begin
                pulses++;
                at = k;
            end
        end
        check_val("timeout_pulses", pulses, 1);
        check_val("timeout_at", at, 16);
        check_val("timeout_sticky", int'(sticky_o[3]), 1);
        drive(1, 0, 16'h0050, 1, 0, 0);
        step();
        check_val("timeout_ack_viol", int'(viol_o), 0);
        check_val("timeout_ack_outs", int'(outstanding_o), 0);
        drive(1, 0, 16'h0050, 0, 0, 0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (viol_o != 7'h00) pulses++;
        end
        check_val("post_ack_quiet", pulses, 0);
        drive(0, 0, 16'h0000, 0, 0, 0);
        step();

        // Response without cycle every cycle drives viol_cnt into saturation.
        drive(0, 0, 16'h0000, 1, 0, 0);
        repeat (260) step();
        check_val("sat_vcnt", int'(viol_cnt_o), 255);
        check_val("sat_viol", int'(viol_o), 2);
        step();
        check_val("sat_hold", int'(viol_cnt_o), 255);

        drive(0, 0, 16'h0000, 0, 0, 0);
        clr_i = 1'b1;
        step();
        check_st("clear", '{7'h00, 3'd0, 7'h00, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 3'd0});
        clr_i = 1'b0;
        step();
        check_val("clear_irq_drop", int'(irq_o), 0);

        drive(0, 0, 16'h0000, 1, 0, 0);
        clr_i = 1'b1;
        step();
        check_st("clear_and_viol", '{7'h02, 3'd0, 7'h02, 8'd0, 8'd0, 8'd1, 1'b0, 1'b1, 3'd1});
        clr_i = 1'b0;
        drive(0, 0, 16'h0000, 0, 0, 0);
        en_mask_i = 7'h02;
        step();
        check_val("irq_mask1", int'(irq_o), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
